axis_rr_arbiter: RTL and testbench



---
 rtl/axis_arb_pkg.sv | 44 ++++
 rtl/axis_skid_buffer.sv | 50 +++++
 rtl/axis_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

    // Widest supported requester count and the index width it needs.
    localparam int unsigned MAX_PORTS   = 16;
    localparam int unsigned IDX_MAX_W   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
    function automatic rr_pick_t rr_select(
        input logic [MAX_PORTS-1:0] valid,
        input logic [IDX_MAX_W-1:0] ptr,
        input int unsigned          n
    );
        rr_pick_t    pick;
        int unsigned j;
        pick = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            if (k < n && !pick.found) begin
                j = (32'(ptr) + k) % n;
                if (valid[IDX_MAX_W'(j)]) begin
                    pick.found = 1'b1;
                    pick.idx   = IDX_MAX_W'(j);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid register: registers valid/data and breaks the ready path.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    // Ready depends only on registered state, so no combinational ready path.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main register feeds the port; the skid register catches the beat
    // accepted in the cycle the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (out_ready || !main_valid) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_valid;
                if (in_valid) begin
                    main_data <= in_data;
                end
            end
        end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging PORTS AXI-Stream requesters into one stream
// tagged with the source index. Grants are held for up to BURST_LEN beats.
// Optional output register stage: define AXIS_RR_ARBITER_OUTPUT_REG_EN.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORTS-1:0]               input_valid,
    output logic [PORTS-1:0]               input_ready,
    input  logic [PORTS*DATA_WIDTH-1:0]    input_data,
    output logic                           output_valid,
    input  logic                           output_ready,
    output logic [DATA_WIDTH-1:0]          output_data,
    output logic [idx_width(PORTS)-1:0]    output_id
);

    localparam int unsigned IW = idx_width(PORTS);
    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    arb_state_t      state, state_n;
    logic [IW-1:0]   grant, grant_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [CW-1:0]   beat_cnt, beat_cnt_n;

    logic                  core_valid;
    logic                  core_ready;
    logic [DATA_WIDTH-1:0] core_data;
    logic                  xfer;
    logic                  last_beat;
    rr_pick_t              pick;

    // Granted requester is passed straight through while locked.
    always_comb begin
        core_data   = input_data[grant*DATA_WIDTH +: DATA_WIDTH];
        core_valid  = 1'b0;
        input_ready = '0;
        if (state == LOCKED) begin
            core_valid         = input_valid[grant];
            input_ready[grant] = core_ready;
        end
    end

    // Next-state: pick in IDLE, count beats and release in LOCKED.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        pick       = rr_select(MAX_PORTS'(input_valid), IDX_MAX_W'(rr_ptr), PORTS);
        xfer       = core_valid && core_ready;
        last_beat  = (beat_cnt == CW'(BURST_LEN - 1));
        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n    = LOCKED;
                    grant_n    = IW'(pick.idx);
                    beat_cnt_n = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                end
                // Final-beat transfer releases even if the requester stays valid.
                if ((xfer && last_beat) || !input_valid[grant]) begin
                    state_n  = IDLE;
                    rr_ptr_n = (grant == IW'(PORTS - 1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

`ifdef AXIS_RR_ARBITER_OUTPUT_REG_EN
    // Beats are counted on acceptance into the skid stage, not at the port.
    logic [DATA_WIDTH+IW-1:0] skid_out;

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + IW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (core_valid),
        .in_ready  (core_ready),
        .in_data   ({grant, core_data}),
        .out_valid (output_valid),
        .out_ready (output_ready),
        .out_data  (skid_out)
    );

    assign output_id   = skid_out[DATA_WIDTH +: IW];
    assign output_data = skid_out[DATA_WIDTH-1:0];
`else
    assign core_ready   = output_ready;
    assign output_valid = core_valid;
    assign output_data  = core_data;
    assign output_id    = grant;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter (default build, PORTS=4, BURST_LEN=4).
module tb_axis_rr_arbiter;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    input_valid;
    logic [P-1:0]    input_ready;
    logic [P*DW-1:0] input_data;
    logic            output_valid;
    logic            output_ready;
    logic [DW-1:0]   output_data;
    logic [IW-1:0]   output_id;

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .PORTS      (P),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_id    (output_id)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] src [P];
    bit            auto_inc;

    // Reference model: who owns the stream, how many beats it has sent,
    // and where the next round-robin search begins.
    bit m_known = 1'b0;
    bit m_busy;
    int m_holder;
    int m_sent;
    int m_next;
    bit m_fire;

    // Transfers observed on the DUT output.
    int            got_id[$];
    logic [DW-1:0] got_data[$];

    typedef struct {
        bit           rst;
        logic [P-1:0] v;
        bit           ordy;
        bit           chk;
        bit           ev;
        logic [P-1:0] er;
        int           eid;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < P; i++) input_data[i*DW +: DW] = src[i];
    endtask

    task automatic model_check();
        logic [P-1:0] er;
        if (output_valid === 1'b1 && output_ready === 1'b1) begin
            got_id.push_back(int'(output_id));
            got_data.push_back(output_data);
        end
        if (m_known) begin
            er = '0;
            if (m_busy) er[m_holder] = output_ready;
            check("model_valid", 32'(output_valid), 32'(m_busy && input_valid[m_holder]));
            check("model_ready", 32'(input_ready), 32'(er));
            check("model_id", 32'(output_id), m_holder);
            check("model_data", output_data, src[m_holder]);
        end
    endtask

    task automatic model_advance();
        bit found;
        int j;
        m_fire = 1'b0;
        if (rst) begin
            m_known  = 1'b1;
            m_busy   = 1'b0;
            m_holder = 0;
            m_sent   = 0;
            m_next   = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < P; k++) begin
                    j = (m_next + k) % P;
                    if (!found && input_valid[j]) begin
                        found    = 1'b1;
                        m_holder = j;
                        m_busy   = 1'b1;
                        m_sent   = 0;
                    end
                end
            end else begin
                m_fire = input_valid[m_holder] && output_ready;
                if (m_fire) begin
                    m_sent++;
                    if (auto_inc) src[m_holder] = src[m_holder] + 1;
                end
                if ((m_fire && m_sent == BL) || !input_valid[m_holder]) begin
                    m_busy = 1'b0;
                    m_next = (m_holder + 1) % P;
                end
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        input_valid = '0;
        repeat (2) step();
        rst = 1'b0;
        check("rst_valid", 32'(output_valid), 32'd0);
        check("rst_ready", 32'(input_ready), 32'd0);
        check("rst_id", 32'(output_id), 32'd0);
        got_id.delete();
        got_data.delete();
    endtask

    initial begin
        rst          = 1'b1;
        input_valid  = '0;
        output_ready = 1'b1;
        auto_inc     = 1'b0;
        for (int i = 0; i < P; i++) src[i] = 32'hA000_0000 + i;
        drive();

        //          rst  valid    ordy chk  ev  ready    id
        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 0};
        tbl[3]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 0};
        tbl[4]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[5]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[7]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[8]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2};
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0000, 2};
        tbl[10] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
        tbl[11] = '{1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b0100, 2};
        tbl[12] = '{1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b0000, 2};
        tbl[13] = '{1'b0, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
        tbl[14] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1000, 3};
        tbl[15] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 3};
        tbl[16] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 0};
        tbl[17] = '{1'b1, 4'b0011, 1'b1, 1'b1, 1'b1, 4'b0001, 0};
        tbl[18] = '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 4'b0000, 0};
        tbl[19] = '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 4'b0001, 0};

        // Directed vector table with constant per-port data.
        for (int n = 0; n < NV; n++) begin
            rst          = tbl[n].rst;
            input_valid  = tbl[n].v;
            output_ready = tbl[n].ordy;
            drive();
            @(negedge clk);
            if (tbl[n].chk) begin
                check($sformatf("tbl%0d_valid", n), 32'(output_valid), 32'(tbl[n].ev));
                check($sformatf("tbl%0d_ready", n), 32'(input_ready), 32'(tbl[n].er));
                check($sformatf("tbl%0d_id", n), 32'(output_id), tbl[n].eid);
                check($sformatf("tbl%0d_data", n), output_data, 32'hA000_0000 + tbl[n].eid);
            end
            model_check();
            model_advance();
            @(posedge clk);
            #1;
        end

        // Reset then idle for 10 cycles.
        auto_inc = 1'b1;
        output_ready = 1'b1;
        do_reset();
        repeat (10) step();
        check("idle_no_beats", got_id.size(), 0);

        // Single requester streaming: 8 beats in 10 cycles.
        src[2] = 32'h100;
        input_valid = 4'b0100;
        repeat (10) step();
        check("single_count", got_id.size(), 8);
        for (int k = 0; k < got_id.size() && k < 8; k++) begin
            check($sformatf("single_id%0d", k), got_id[k], 2);
            check($sformatf("single_data%0d", k), got_data[k], 32'h100 + k);
        end

        // Round-robin fairness with all requesters valid.
        do_reset();
        for (int i = 0; i < P; i++) src[i] = 32'(i) << 12;
        input_valid = 4'b1111;
        repeat (25) step();
        check("rr_count", got_id.size(), 20);
        for (int k = 0; k < got_id.size() && k < 20; k++) begin
            check($sformatf("rr_id%0d", k), got_id[k], (k / 4) % 4);
            check($sformatf("rr_data%0d", k), got_data[k],
                  (32'((k / 4) % 4) << 12) + 32'((k / 16) * 4 + k % 4));
        end

        // Backpressure on requester 1.
        do_reset();
        src[1] = 32'h200;
        input_valid = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            output_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            step();
        end
        check("bp_release", 32'(output_valid), 32'd0);
        check("bp_count", got_id.size(), 4);
        if (got_data.size() == 4) check("bp_last", got_data[3], 32'h203);
        output_ready = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < P; i++) begin
                if (input_valid[i]) begin
                    if ((rst || (m_fire && m_holder == i)) && $urandom_range(3) == 0)
                        input_valid[i] = 1'b0;
                end else if ($urandom_range(9) < 4) begin
                    input_valid[i] = 1'b1;
                end
            end
            output_ready = ($urandom_range(9) < 7);
            rst          = ($urandom_range(99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
